fnd_scan_driver: RTL and testbench
==================================

# fnd_scan_driver

Time-multiplexed N-digit seven-segment (FND) driver. It double-buffers a packed digit/decimal-point word and scans one digit per slot. Each digit is decoded to an active-low segment font with a configurable anti-ghosting blank interval. It sits between any value source (counter, MicroBlaze GPIO) and the board's common-anode FND pins, and succeeds the single-digit combinational BCD-to-FND decoder.

## Interface
- NUM_DIGITS, 4, digit count; legal range 1..8
- SCAN_DIV, 100000, clock cycles per digit slot; must be >= 2
- BLANK_CYCLES, 1000, cycles at slot start with all commons off; must be < SCAN_DIV
- HEX_MODE, 0, 0 = BCD fonts, 1 = hex fonts A–F
- i_clk  in  1  system clock; all logic on rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_valid  in  1  write strobe for i_value/i_dp
- i_value  in  4*NUM_DIGITS  packed digit codes; digit k = [4k+3:4k]; digit NUM_DIGITS-1 is most significant
- i_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- o_font  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- o_com  out  NUM_DIGITS  digit commons, active-low, at most one low
- o_frame  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0

## Operation
- Registers:
  - slot counter, width $clog2(SCAN_DIV)
  - digit index, width max(1,$clog2(NUM_DIGITS))
  - pending buffer {value, dp} plus pending flag
  - active buffer {value, dp}
- Slot counter: counts 0..SCAN_DIV-1 and wraps.
  - At wrap, the index increments.
  - The index wraps NUM_DIGITS-1 → 0; that event is the frame boundary.
- Write: on i_valid=1, the pending buffer is loaded and the pending flag set. Back-to-back writes overwrite; the last write wins.
- Frame boundary:
  - If the pending flag is set, active ← pending and the flag clears.
  - If i_valid=1 in the same cycle, active takes i_value/i_dp directly and the flag stays clear.
  - Active never changes mid-frame.
- Font for code c, BCD mode:
  - 0..9 → C0,F9,A4,B0,99,92,82,F8,80,90
  - A → 7F (dot only)
  - B..F → FF
- HEX_MODE=1: 0..9 as BCD; A..F → 88,83,C6,A1,86,8E.
- A digit's dp=1 clears bit 7 of its font.
- Blank interval: while slot counter < BLANK_CYCLES, o_com is all ones. o_font still shows the current digit's font.
- Otherwise o_com = ~(1 << index).
- o_frame is asserted for the single cycle in which the index register changes NUM_DIGITS-1 → 0.

## Timing
- Reset (i_reset_n=0 at a rising edge):
  - o_font=FF, o_com=all ones, o_frame=0
  - slot counter=0, index=0
  - pending and active = 0, pending flag clear
- Reset mid-frame discards both buffers at once.
- All outputs are registered. o_font/o_com reflect the index and counter values from the previous cycle (1-cycle latency).
- First cycle after reset release: o_com all ones (counter 0 < BLANK_CYCLES), o_font=C0. Digit 0 commons go low at cycle BLANK_CYCLES+1.
- A write reaches the display at the next frame boundary: worst case NUM_DIGITS*SCAN_DIV+1 cycles after i_valid.
- i_valid has no backpressure and is always accepted.

## Configuration
- FND_LEADING_ZERO_BLANK_EN defined:
  - Active digits from NUM_DIGITS-1 downward whose code is 0, up to the first nonzero code, display FF except for their dp segment.
  - Digit 0 is never blanked.
  - Only a code exactly 0 counts as a leading zero.
- Undefined: every digit is decoded normally.

## Test plan
Bench parameters: NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
- Reset hold then release: o_font=FF and o_com=F during reset. After release, o_com sequence 1 blank cycle then E for 3 cycles, then D, B, 7 in the same pattern. o_frame pulses every 16 cycles.
- i_value=16'h1234, i_dp=4'b0100, one-cycle i_valid mid-frame: unchanged until the next o_frame. Then digits 0..3 show 99, B0, 24 (dp lit), F9.
- HEX_MODE=1, i_value=16'hABCF: fonts 8E, C6, 83, 88 on digits 0..3. HEX_MODE=0, same value: FF, FF, FF, 7F.
- i_valid=1 exactly in the boundary cycle with 16'h5678, after a pending 16'h1111: new frame shows 5678, and the pending flag is clear afterwards.
- FND_LEADING_ZERO_BLANK_EN, i_value=16'h0070: digits 3,2 = FF; digit 1 = F8; digit 0 = C0. 16'h0000 shows only digit 0 = C0.
- Assert i_reset_n=0 for 1 cycle mid-slot on digit 2: next cycle outputs FF/F, and the scan restarts at digit 0 with active = 0.

Source files
------------

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: time-multiplexed N-digit active-low FND driver with double-buffered value; FND_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module fnd_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int HEX_MODE     = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_valid,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic [7:0]              o_font,
  output logic [NUM_DIGITS-1:0]   o_com,
  output logic                    o_frame
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         pend_val_q, pend_val_d, act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic                  pend_q, pend_d;
  logic [7:0]            font_q, font_d;
  logic [NUM_DIGITS-1:0] com_q, com_d;
  logic                  frame_q, frame_d;
  logic                  wrap_slot, last, boundary, blank, dp;
  logic [3:0]            code;
  function automatic logic [7:0] seg(input logic [3:0] c);
    case (c)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      4'd10:   seg = HEX_MODE != 0 ? 8'h88 : 8'h7F;
      4'd11:   seg = HEX_MODE != 0 ? 8'h83 : 8'hFF;
      4'd12:   seg = HEX_MODE != 0 ? 8'hC6 : 8'hFF;
      4'd13:   seg = HEX_MODE != 0 ? 8'hA1 : 8'hFF;
      4'd14:   seg = HEX_MODE != 0 ? 8'h86 : 8'hFF;
      default: seg = HEX_MODE != 0 ? 8'h8E : 8'hFF;
    endcase
  endfunction
`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  lz_run;
  // leading-zero mask: a digit is blank while every more significant code is also 0; digit 0 never blanks
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lz_run = lz_run & (act_val_q[4*k +: 4] == 4'd0);
      lz[k]  = lz_run;
    end
  end
  assign blank = lz[idx_q];
`else
  assign blank = 1'b0;
`endif
  // scan timing, buffer handoff at the frame boundary, and next registered outputs
  always_comb begin
    wrap_slot  = cnt_q == CW'(SCAN_DIV - 1);
    last       = idx_q == IW'(NUM_DIGITS - 1);
    boundary   = wrap_slot && last;
    cnt_d      = wrap_slot ? '0 : cnt_q + 1'b1;
    idx_d      = wrap_slot ? (last ? '0 : idx_q + 1'b1) : idx_q;
    pend_val_d = (i_valid && !boundary) ? i_value : pend_val_q;
    pend_dp_d  = (i_valid && !boundary) ? i_dp : pend_dp_q;
    pend_d     = boundary ? 1'b0 : (pend_q | i_valid);
    act_val_d  = !boundary ? act_val_q : i_valid ? i_value : pend_q ? pend_val_q : act_val_q;
    act_dp_d   = !boundary ? act_dp_q : i_valid ? i_dp : pend_q ? pend_dp_q : act_dp_q;
    code       = 4'(act_val_q >> {idx_q, 2'b00});
    dp         = act_dp_q[idx_q];
    font_d     = (blank ? 8'hFF : seg(code)) & {~dp, 7'h7F};
    com_d      = cnt_q < CW'(BLANK_CYCLES) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    frame_d    = boundary;
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_q     <= 1'b0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      font_q     <= 8'hFF;
      com_q      <= '1;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      font_q     <= font_d;
      com_q      <= com_d;
      frame_q    <= frame_d;
    end
  end
  assign o_font  = font_q;
  assign o_com   = com_q;
  assign o_frame = frame_q;
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed checks of scan sequence, buffering and fonts for BCD and hex builds
module tb_fnd_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n, valid;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [7:0]  font, font_h;
  logic [3:0]  com, com_h;
  logic        frame, frame_h;
  int          n_run = 0, n_fail = 0;
  logic [7:0]  fb [4];
  logic [7:0]  fh [4];
  logic [31:0] zf;
  logic [3:0]  ecom [16];
  logic        bad;
  always #5 clk = ~clk;
  fnd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_value(value), .i_dp(dp),
    .o_font(font), .o_com(com), .o_frame(frame));
  fnd_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1)) dut_h (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .i_value(value), .i_dp(dp),
    .o_font(font_h), .o_com(com_h), .o_frame(frame_h));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic write(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
  endtask
  task automatic wait_frame(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (frame) break;
      step(1);
    end
    if (!frame) check({tag, "_frame_timeout"}, 32'd0, 32'd1);
  endtask
  task automatic capture(input string tag);
    wait_frame(tag);
    for (int k = 0; k < 4; k++) begin
      fb[k] = 8'h00;
      fh[k] = 8'h00;
    end
    for (int c = 0; c < 16; c++) begin
      step(1);
      for (int k = 0; k < 4; k++) begin
        if (com == ~(4'd1 << k)) fb[k] = font;
        if (com_h == ~(4'd1 << k)) fh[k] = font_h;
      end
    end
  endtask
  task automatic expect4(input string tag, input logic [31:0] eb, input logic [31:0] eh);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_bcd_d%0d", tag, k), 32'(fb[k]), 32'(eb[8*k +: 8]));
      check($sformatf("%s_hex_d%0d", tag, k), 32'(fh[k]), 32'(eh[8*k +: 8]));
    end
  endtask
  initial begin
`ifdef FND_LEADING_ZERO_BLANK_EN
    zf = 32'hFFFFFFC0;
`else
    zf = 32'hC0C0C0C0;
`endif
    ecom = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
             4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    rst_n = 1'b0;
    valid = 1'b0;
    value = '0;
    dp    = '0;
    step(3);
    check("rst_font", 32'(font), 32'hFF);
    check("rst_com", 32'(com), 32'hF);
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_font_hex", 32'(font_h), 32'hFF);
    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step(1);
      if (c == 1) check("rel_font", 32'(font), 32'hC0);
      check($sformatf("rel_com_%0d", c), 32'(com), 32'(ecom[c-1]));
      check($sformatf("rel_frame_%0d", c), 32'(frame), (c == 16) ? 32'd1 : 32'd0);
    end
    step(5);
    write(16'h1234, 4'b0100);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (frame) break;
      for (int k = 0; k < 4; k++)
        if (com == ~(4'd1 << k) && font !== zf[8*k +: 8]) bad = 1'b1;
      step(1);
    end
    check("hold_until_frame", 32'(bad), 32'd0);
    capture("v1234");
    expect4("v1234", 32'hF924B099, 32'hF924B099);
    write(16'hABCF, 4'b0000);
    capture("vABCF");
    expect4("vABCF", 32'h7FFFFFFF, 32'h8883C68E);
    wait_frame("bnd");
    step(5);
    write(16'h1111, 4'b0000);
    step(9);
    write(16'h5678, 4'b0000);
    check("bnd_frame", 32'(frame), 32'd1);
    capture("bnd1");
    expect4("bnd1", 32'h9282F880, 32'h9282F880);
    capture("bnd2");
    expect4("bnd2", 32'h9282F880, 32'h9282F880);
`ifdef FND_LEADING_ZERO_BLANK_EN
    write(16'h0070, 4'b0000);
    capture("lz0070");
    expect4("lz0070", 32'hFFFFF8C0, 32'hFFFFF8C0);
    write(16'h0000, 4'b0000);
    capture("lz0000");
    expect4("lz0000", 32'hFFFFFFC0, 32'hFFFFFFC0);
`endif
    wait_frame("mrst");
    step(8);
    write(16'h1111, 4'b1111);
    rst_n = 1'b0;
    step(1);
    check("mrst_font", 32'(font), 32'hFF);
    check("mrst_com", 32'(com), 32'hF);
    check("mrst_frame", 32'(frame), 32'h0);
    rst_n = 1'b1;
    step(1);
    check("mrst_font1", 32'(font), 32'hC0);
    check("mrst_com1", 32'(com), 32'hF);
    step(1);
    check("mrst_com2", 32'(com), 32'hE);
    capture("mrst");
    expect4("mrst", zf, zf);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
